// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// per-stage destination tags and controller states.
package pipe_ctrl_pkg;

  localparam int TAG_RD_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                we;
    logic                is_load;
    logic                is_halt;
  } stage_tag_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  localparam stage_tag_t ZERO_TAG = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Priority search of in-flight tags for one source operand;
// youngest matching stage wins, register 0 never matches.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = 2
) (
  input  stage_tag_t [PIPE_DEPTH-1:0] tags_i,
  input  logic [REG_W-1:0]            src_i,
  input  logic                        used_i,
  output logic [SEL_W-1:0]            sel_o,
  output logic                        load_haz_o
);

  logic                found;
  logic [TAG_RD_W-1:0] src_ext;

  always_comb begin
    sel_o      = '0;
    load_haz_o = 1'b0;
    found      = 1'b0;
    src_ext    = TAG_RD_W'(src_i);
    for (int s = 0; s < PIPE_DEPTH; s++) begin
      if (!found && used_i && (src_i != '0) &&
          tags_i[s].valid && tags_i[s].we &&
          (tags_i[s].rd == src_ext)) begin
        found      = 1'b1;
        sel_o      = SEL_W'(s + 1);
        load_haz_o = tags_i[s].is_load && ((s + 1) <= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Owner of stage advance: forwarding selects, load-use stall,
// redirect flush, cache freeze and halt drain sequencing.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int REG_W      = $clog2(NUM_REGS),
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs_num,
  input  logic [REG_W-1:0] id_rt_num,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd_num,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             id_is_halt,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pipe_adv,
  output logic             if_hold,
  output logic             id_flush,
  output logic             ex_bubble,
  output logic [SEL_W-1:0] fwd_rs_sel,
  output logic [SEL_W-1:0] fwd_rt_sel,
  output logic             draining,
  output logic             halted
);

  ctrl_state_e                 state_q, state_d;
  stage_tag_t [PIPE_DEPTH-1:0] tags_q, tags_d;
  stage_tag_t                  new_tag;

  logic rs_haz, rt_haz, load_use;
  logic st_run, st_drain, st_halt;
  logic redirect, halt_go;

  fwd_select #(
    .REG_W      (REG_W),
    .PIPE_DEPTH (PIPE_DEPTH),
    .LOAD_LAT   (LOAD_LAT),
    .SEL_W      (SEL_W)
  ) u_fwd_rs (
    .tags_i     (tags_q),
    .src_i      (id_rs_num),
    .used_i     (id_rs_used),
    .sel_o      (fwd_rs_sel),
    .load_haz_o (rs_haz)
  );

  fwd_select #(
    .REG_W      (REG_W),
    .PIPE_DEPTH (PIPE_DEPTH),
    .LOAD_LAT   (LOAD_LAT),
    .SEL_W      (SEL_W)
  ) u_fwd_rt (
    .tags_i     (tags_q),
    .src_i      (id_rt_num),
    .used_i     (id_rt_used),
    .sel_o      (fwd_rt_sel),
    .load_haz_o (rt_haz)
  );

  always_comb begin
    st_run    = (state_q == RUN);
    st_drain  = (state_q == DRAIN);
    st_halt   = (state_q == HALTED);
    load_use  = rs_haz | rt_haz;
    // The halt is youngest while draining, so a redirect then is bogus.
    redirect  = ex_redirect & st_run;
    pipe_adv  = !mem_busy & !st_halt;
    if_hold   = mem_busy | !st_run | (load_use & !redirect);
    id_flush  = redirect;
    ex_bubble = redirect | st_drain | (st_run & load_use);
    draining  = st_drain;
    halted    = st_halt;
    halt_go   = st_run & pipe_adv & id_valid & id_is_halt &
                !load_use & !ex_redirect;
  end

  always_comb begin
    new_tag         = ZERO_TAG;
    new_tag.valid   = id_valid;
    new_tag.rd      = TAG_RD_W'(id_rd_num);
    new_tag.we      = id_rd_we;
    new_tag.is_load = id_is_load;
    new_tag.is_halt = id_is_halt;
    if (ex_bubble) new_tag = ZERO_TAG;
    tags_d = tags_q;
    if (pipe_adv) begin
      tags_d[0] = new_tag;
      for (int s = 1; s < PIPE_DEPTH; s++) tags_d[s] = tags_q[s-1];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (halt_go) state_d = DRAIN;
      DRAIN:   if (pipe_adv && tags_q[PIPE_DEPTH-1].valid &&
                   tags_q[PIPE_DEPTH-1].is_halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= RUN;
      tags_q  <= '0;
    end else begin
      state_q <= state_d;
      tags_q  <= tags_d;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline control block for the MIPS core. It tracks in-flight destination tags for each stage after decode. It generates forwarding selects, load-use stalls, redirect flushes and the global freeze from the data cache, and sequences a halt drain so `halted` rises only after every older instruction has retired. It sits beside ID and replaces the scattered `cache_done`/`jmp_freeze` gating with one owner of stage advance.

## Interface
- `NUM_REGS`, 32: architectural registers; `REG_W = $clog2(NUM_REGS)`.
- `PIPE_DEPTH`, 3: tracked stages after ID (stage 1 = EX … stage `PIPE_DEPTH` = WB); legal 2..6.
- `LOAD_LAT`, 1: a load in stage s ≤ `LOAD_LAT` cannot forward; legal 1..`PIPE_DEPTH`-1.
- `SEL_W`, `$clog2(PIPE_DEPTH+1)`: forward-select width.

Ports:
- `clk` in 1: clock.
- `rst_b` in 1: asynchronous, active-low reset. One clock; reset asynchronous active-low.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs_num`, `id_rt_num` in `REG_W`: ID source registers.
- `id_rs_used`, `id_rt_used` in 1: the source is actually read.
- `id_rd_num` in `REG_W`, `id_rd_we` in 1: ID destination and write enable (GPR or coprocessor tag, already muxed).
- `id_is_load` in 1, `id_is_halt` in 1: ID instruction class.
- `ex_redirect` in 1: EX resolved a taken branch or jump.
- `mem_busy` in 1: cache not done (`!cache_done`).
- `pipe_adv` out 1: all stage registers may load this cycle.
- `if_hold` out 1: PC and IF/ID hold.
- `id_flush` out 1: IF/ID loads a bubble.
- `ex_bubble` out 1: ID/EX loads a bubble instead of the ID instruction.
- `fwd_rs_sel`, `fwd_rt_sel` out `SEL_W`: 0 = regfile, s = result of stage s.
- `draining` out 1: halt drain in progress.
- `halted` out 1: sticky halt.

## Operation
- Tag pipeline: `PIPE_DEPTH` entries {valid, rd, we, is_load, is_halt}. It shifts only when `pipe_adv`. Entry 1 takes the ID tag unless `ex_bubble`, in which case it takes an all-zero tag. Entry `PIPE_DEPTH` retires.
- Forward search: per source, the lowest s with valid & we & rd == src & src != 0. `sel` = s, or 0 if no match or the source is unused. Register 0 never forwards.
- Load-use: the matching entry has is_load and s ≤ `LOAD_LAT` → `if_hold`=1, `ex_bubble`=1.
- Redirect: `ex_redirect` → `id_flush`=1, `ex_bubble`=1, `if_hold`=0 (PC takes the target). Redirect overrides load-use and squashes a halt in ID.
- Freeze: `mem_busy` → `pipe_adv`=0, `if_hold`=1, and no tag shift. Flush and bubble outputs still indicate intent but take effect only on an advancing cycle.
- FSM RUN → DRAIN: advancing cycle with `id_valid` & `id_is_halt`, not stalled, not redirected. The halt tag enters stage 1.
- DRAIN: `if_hold`=1, `ex_bubble`=1, `draining`=1.
- DRAIN → HALTED: an advancing cycle on which the halt tag sits in stage `PIPE_DEPTH`.
- HALTED: `halted`=1 and `pipe_adv`=0. The state holds until reset.
- Redirect during DRAIN cannot occur: the halt is youngest. It is ignored if asserted.

## Timing
- Reset (async): all tags invalid, FSM=RUN.
  - Reset outputs: `pipe_adv`=1, holds/flush/bubble=0, selects=0, `draining`=0, `halted`=0.
- All outputs are combinational from state plus current inputs. Zero-cycle latency inside the cycle.
- Load-use costs exactly one bubble for `LOAD_LAT`=1, or (`LOAD_LAT`−s+1) cycles in general.
- Redirect costs two squashed slots (IF/ID, ID/EX).
- Halt: `halted` rises on the clock edge after the halt retires from stage `PIPE_DEPTH`. This is `PIPE_DEPTH` advancing cycles after entry, plus any `mem_busy` cycles.
- Reset mid-drain or mid-freeze returns to RUN and clears all tags immediately.

## Structure
- Package `pipe_ctrl_pkg`:
  - `stage_tag_t` struct.
  - `ctrl_state_e` {RUN, DRAIN, HALTED}.
  - Zero-tag constant.
- Sub-module `fwd_select`: combinational priority search over the tag array, returning sel plus a load-hazard flag. Instantiated twice (rs, rt).

## Test plan
- `add $3`, then immediately `sub` reading `$3` → `fwd_rs_sel`=1. One cycle later a reader of `$3` sees sel=2, then 3, then 0.
- `lw $5`, then `add` reading `$5` (`LOAD_LAT`=1) → one cycle of `if_hold`=1, `ex_bubble`=1, then `fwd`=2.
- Write to `$0` followed by a reader of `$0` → sel=0, no stall.
- `ex_redirect` coinciding with a load-use stall and a halt in ID → `id_flush`=1, `ex_bubble`=1, `if_hold`=0, FSM stays RUN.
- `mem_busy` held 4 cycles while a load is in stage 1 → no shift. The stall persists, then resolves one advance after `mem_busy` drops.
- Halt with `PIPE_DEPTH`=3, no `mem_busy` → `draining` for 3 cycles, `halted`=1 on the 4th edge. Assert `rst_b`=0 during DRAIN → `halted`=0, tags cleared.
